// File: rtl/unidad_busqueda.sv
// -----------------------------------------------------------------------------
// unidad_busqueda
//
// Instruction-fetch sequencer. Holds the program counter, requests one 32-bit
// word at a time from instruction memory over a req/ack handshake and hands
// each fetched word downstream together with the address it came from. That
// address also feeds the branch-target adder, whose result comes back on
// result_suma as a redirect target.
//
// Parameters
//   ANCHO             address width in bits
//   PC_RESET          program counter after reset (4-byte aligned)
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   salto_valido      redirect request, target on result_suma this cycle
//   result_suma       branch target from the adder
//   stall             downstream cannot take the delivered instruction
//   im_dir            address presented to instruction memory
//   im_req            memory request
//   im_ack            memory acknowledge, im_dato valid in the same cycle
//   im_dato           instruction word from memory
//   instruccion       delivered instruction
//   instr_valida      instruccion / bus_direccion_im are valid
//   bus_direccion_im  address of instruccion (adder operand)
//   error_alineacion  sticky flag: a redirect target was not word aligned
// -----------------------------------------------------------------------------
module unidad_busqueda #(
    parameter int               ANCHO    = 64,
    parameter logic [ANCHO-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             salto_valido,
    input  logic [ANCHO-1:0] result_suma,
    input  logic             stall,
    output logic [ANCHO-1:0] im_dir,
    output logic             im_req,
    input  logic             im_ack,
    input  logic [31:0]      im_dato,
    output logic [31:0]      instruccion,
    output logic             instr_valida,
    output logic [ANCHO-1:0] bus_direccion_im,
    output logic             error_alineacion
);

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        PEDIR    = 2'd1,
        ENTREGAR = 2'd2,
        ERROR    = 2'd3
    } estado_t;

    estado_t          estado, estado_sig;
    logic             arranque;          // set on the first edge after reset
    logic [ANCHO-1:0] pc, pc_sig;
    logic [ANCHO-1:0] destino_pend, destino_sig;
    logic             pend, pend_sig;
    logic             capturar;          // latch im_dato and its address

    // A misaligned target wins over everything else in the same cycle.
    logic salto_desalineado;
    assign salto_desalineado = salto_valido && (result_suma[1:0] != 2'b00);

    // The memory address is the PC register itself, so it is a flop output.
    assign im_dir = pc;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; the combinational blocks below use blocking (=).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= INICIO;
            arranque <= 1'b0;
        end else begin
            estado   <= estado_sig;
            arranque <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of each always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        estado_sig = estado;
        case (estado)
            // Stay one full cycle after reset release, then start fetching.
            INICIO: begin
                if (salto_desalineado) estado_sig = ERROR;
                else if (arranque)     estado_sig = PEDIR;
            end
            // A redirect (latched or same-edge) turns the ack into a discard.
            PEDIR: begin
                if (salto_desalineado)                        estado_sig = ERROR;
                else if (im_ack && !(pend || salto_valido))   estado_sig = ENTREGAR;
            end
            // A redirect flushes the held word even under stall.
            ENTREGAR: begin
                if (salto_desalineado)              estado_sig = ERROR;
                else if (salto_valido || !stall)    estado_sig = PEDIR;
            end
            // Only reset leaves ERROR.
            ERROR:   estado_sig = ERROR;
            default: estado_sig = ERROR;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        pc_sig      = pc;
        destino_sig = destino_pend;
        pend_sig    = pend;
        capturar    = 1'b0;
        if (!salto_desalineado) begin
            case (estado)
                PEDIR: begin
                    if (im_ack) begin
                        if (salto_valido) begin
                            // Newest target beats any older latched one.
                            pc_sig   = result_suma;
                            pend_sig = 1'b0;
                        end else if (pend) begin
                            pc_sig   = destino_pend;
                            pend_sig = 1'b0;
                        end else begin
                            capturar = 1'b1;
                            pc_sig   = pc + ANCHO'(4);   // wraps modulo 2^ANCHO
                        end
                    end else if (salto_valido) begin
                        // The request in flight must complete before the PC
                        // may move, so park the target until the ack arrives.
                        destino_sig = result_suma;
                        pend_sig    = 1'b1;
                    end
                end
                ENTREGAR: begin
                    if (salto_valido) pc_sig = result_suma;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc               <= PC_RESET;
            destino_pend     <= '0;
            pend             <= 1'b0;
            instruccion      <= '0;
            bus_direccion_im <= '0;
            im_req           <= 1'b0;
            instr_valida     <= 1'b0;
            error_alineacion <= 1'b0;
        end else begin
            pc           <= pc_sig;
            destino_pend <= destino_sig;
            pend         <= pend_sig;
            if (capturar) begin
                instruccion      <= im_dato;
                bus_direccion_im <= pc;
            end
            // Handshake flags are registered copies of the next state.
            im_req           <= (estado_sig == PEDIR);
            instr_valida     <= (estado_sig == ENTREGAR);
            error_alineacion <= (estado_sig == ERROR);
        end
    end

endmodule

// File: tb/tb_unidad_busqueda.sv
// -----------------------------------------------------------------------------
// tb_unidad_busqueda
//
// Directed scenarios with literal expectations followed by a long randomized
// run. A transaction-level reference (pending-redirect queue, boot counter,
// request/deliver flags) predicts the outputs each cycle; a memory responder
// answers requests with configurable or random latency.
// -----------------------------------------------------------------------------
module tb_unidad_busqueda;

    localparam int          ANCHO = 64;
    localparam logic [63:0] PC_A  = 64'h0000_0000_0000_1000;
    localparam logic [63:0] PC_W  = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        salto_valido = 1'b0;
    logic [63:0] result_suma = '0;
    logic        stall = 1'b0;
    logic        im_ack = 1'b0;
    logic [31:0] im_dato = '0;

    logic [63:0] im_dir, bus_direccion_im;
    logic        im_req, instr_valida, error_alineacion;
    logic [31:0] instruccion;

    logic [63:0] w_im_dir, w_bus;
    logic        w_im_req, w_valida, w_error;
    logic [31:0] w_instr;

    int checks = 0;
    int errors = 0;

    unidad_busqueda #(.ANCHO(ANCHO), .PC_RESET(PC_A)) dut (
        .clk(clk), .reset(reset), .salto_valido(salto_valido),
        .result_suma(result_suma), .stall(stall), .im_dir(im_dir),
        .im_req(im_req), .im_ack(im_ack), .im_dato(im_dato),
        .instruccion(instruccion), .instr_valida(instr_valida),
        .bus_direccion_im(bus_direccion_im), .error_alineacion(error_alineacion)
    );

    // Second instance to observe PC wrap-around; shares all stimulus.
    unidad_busqueda #(.ANCHO(ANCHO), .PC_RESET(PC_W)) dut_wrap (
        .clk(clk), .reset(reset), .salto_valido(salto_valido),
        .result_suma(result_suma), .stall(stall), .im_dir(w_im_dir),
        .im_req(w_im_req), .im_ack(im_ack), .im_dato(im_dato),
        .instruccion(w_instr), .instr_valida(w_valida),
        .bus_direccion_im(w_bus), .error_alineacion(w_error)
    );

    always #5 clk = ~clk;

    task automatic check_b(input string nombre, input logic actual, input logic esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", nombre, actual, esperado, $time);
        end
    endtask

    task automatic check_w(input string nombre, input logic [63:0] actual, input logic [63:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nombre, actual, esperado, $time);
        end
    endtask

    // Directed-phase memory contents: word derived from its address.
    function automatic logic [31:0] palabra(input logic [63:0] d);
        return {16'hC0DE, d[15:0]};
    endfunction

    // ------------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------------
    int ack_delay = 0;
    int wait_cnt  = 0;
    bit ack_aleatorio  = 1'b0;
    bit ack_espurio    = 1'b0;
    bit dato_aleatorio = 1'b0;

    always @(negedge clk) begin
        if (im_req) begin
            if (wait_cnt >= ack_delay) begin
                im_ack   = 1'b1;
                wait_cnt = 0;
                if (ack_aleatorio) ack_delay = int'($urandom_range(0, 3));
            end else begin
                im_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            im_ack   = ack_espurio && ($urandom_range(0, 3) == 0);
            wait_cnt = 0;
        end
        im_dato = dato_aleatorio ? $urandom : palabra(im_dir);
    end

    // ------------------------------------------------------------------------
    // Reference model + per-cycle comparison
    // ------------------------------------------------------------------------
    logic [63:0] m_pc, m_bus;
    logic [31:0] m_instr;
    bit          m_req, m_val, m_err;
    int          m_boot;
    logic [63:0] m_pend[$];

    always @(posedge clk) begin
        if (reset) begin
            m_pc = PC_A; m_bus = '0; m_instr = '0;
            m_req = 1'b0; m_val = 1'b0; m_err = 1'b0; m_boot = 0;
            m_pend.delete();
        end else if (!m_err) begin
            if (salto_valido && result_suma[1:0] != 2'b00) begin
                m_err = 1'b1; m_req = 1'b0; m_val = 1'b0;
            end else if (m_boot < 2) begin
                m_boot++;
                m_req = (m_boot == 2);
            end else if (m_req) begin
                if (im_ack) begin
                    if (salto_valido || m_pend.size() != 0) begin
                        m_pc = salto_valido ? result_suma : m_pend[0];
                        m_pend.delete();
                    end else begin
                        m_instr = im_dato;
                        m_bus   = m_pc;
                        m_pc    = m_pc + 64'd4;
                        m_req   = 1'b0;
                        m_val   = 1'b1;
                    end
                end else if (salto_valido) begin
                    m_pend.delete();
                    m_pend.push_back(result_suma);
                end
            end else if (m_val) begin
                if (salto_valido) begin
                    m_pc = result_suma; m_val = 1'b0; m_req = 1'b1;
                end else if (!stall) begin
                    m_val = 1'b0; m_req = 1'b1;
                end
            end
        end
        #1;
        check_b("m_im_req", im_req, m_req);
        check_w("m_im_dir", im_dir, m_pc);
        check_b("m_instr_valida", instr_valida, m_val);
        check_b("m_error_alineacion", error_alineacion, m_err);
        if (m_val || reset) begin
            check_w("m_instruccion", 64'(instruccion), 64'(m_instr));
            check_w("m_bus_direccion_im", bus_direccion_im, m_bus);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        repeat (2) @(negedge clk);

        // Reset values
        check_w("rst_im_dir", im_dir, PC_A);
        check_w("rst_wrap_im_dir", w_im_dir, PC_W);
        check_b("rst_im_req", im_req, 1'b0);
        check_b("rst_instr_valida", instr_valida, 1'b0);
        check_b("rst_error", error_alineacion, 1'b0);
        check_w("rst_instruccion", 64'(instruccion), 64'h0);
        check_w("rst_bus", bus_direccion_im, 64'h0);
        reset = 1'b0;

        // First edge after release: still idle
        @(negedge clk);
        check_b("boot_no_req", im_req, 1'b0);

        // Zero-wait fetches: 0x1000, 0x1004, 0x1008, one every two cycles
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_b("seq_req", im_req, 1'b1);
            check_b("seq_req_valida", instr_valida, 1'b0);
            check_w("seq_im_dir", im_dir, PC_A + 64'(4 * k));
            if (k == 0) check_w("wrap_dir0", w_im_dir, PC_W);
            if (k == 1) check_w("wrap_dir1", w_im_dir, 64'h0);
            @(negedge clk);
            check_b("seq_valida", instr_valida, 1'b1);
            check_b("seq_no_req", im_req, 1'b0);
            check_w("seq_bus", bus_direccion_im, PC_A + 64'(4 * k));
            check_w("seq_instr", 64'(instruccion), 64'(palabra(PC_A + 64'(4 * k))));
        end

        // Three-cycle ack delay on 0x100C
        ack_delay = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_b("wait_req", im_req, 1'b1);
            check_w("wait_dir", im_dir, 64'h100C);
        end
        @(negedge clk);
        check_b("wait_valida", instr_valida, 1'b1);
        check_w("wait_instr", 64'(instruccion), 64'(palabra(64'h100C)));
        check_w("wait_bus", bus_direccion_im, 64'h100C);
        ack_delay = 0;

        // Stall for four edges
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_b("stall_valida", instr_valida, 1'b1);
            check_b("stall_no_req", im_req, 1'b0);
            check_w("stall_instr", 64'(instruccion), 64'(palabra(64'h100C)));
            check_w("stall_bus", bus_direccion_im, 64'h100C);
        end
        stall = 1'b0;
        @(negedge clk);
        check_b("post_stall_req", im_req, 1'b1);
        check_w("post_stall_dir", im_dir, 64'h1010);
        @(negedge clk);
        check_w("post_stall_bus", bus_direccion_im, 64'h1010);

        // Redirect while delivering (stall does not block it)
        salto_valido = 1'b1; result_suma = 64'h2000; stall = 1'b1;
        @(negedge clk);
        salto_valido = 1'b0; stall = 1'b0;
        check_b("flush_valida", instr_valida, 1'b0);
        check_b("flush_req", im_req, 1'b1);
        check_w("flush_dir", im_dir, 64'h2000);
        @(negedge clk);
        check_b("flush_new_valida", instr_valida, 1'b1);
        check_w("flush_new_bus", bus_direccion_im, 64'h2000);
        check_w("flush_new_instr", 64'(instruccion), 64'(palabra(64'h2000)));

        // Redirect while a request is outstanding
        ack_delay = 2;
        @(negedge clk);
        check_b("pend_req", im_req, 1'b1);
        check_w("pend_dir", im_dir, 64'h2004);
        salto_valido = 1'b1; result_suma = 64'h3000;
        @(negedge clk);
        salto_valido = 1'b0;
        check_w("pend_dir_hold", im_dir, 64'h2004);
        @(negedge clk);
        check_w("pend_dir_hold2", im_dir, 64'h2004);
        ack_delay = 0;
        @(negedge clk);
        check_b("pend_discard_valida", instr_valida, 1'b0);
        check_b("pend_discard_req", im_req, 1'b1);
        check_w("pend_new_dir", im_dir, 64'h3000);
        @(negedge clk);
        check_b("pend_new_valida", instr_valida, 1'b1);
        check_w("pend_new_bus", bus_direccion_im, 64'h3000);

        // Misaligned target
        salto_valido = 1'b1; result_suma = 64'h2002;
        @(negedge clk);
        salto_valido = 1'b0;
        check_b("mis_error", error_alineacion, 1'b1);
        check_b("mis_req", im_req, 1'b0);
        check_b("mis_valida", instr_valida, 1'b0);
        check_w("mis_dir", im_dir, 64'h3004);
        ack_espurio = 1'b1;
        for (int i = 0; i < 5; i++) begin
            salto_valido = 1'b1; result_suma = 64'h4000;
            stall = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            check_b("err_sticky", error_alineacion, 1'b1);
            check_b("err_no_req", im_req, 1'b0);
        end
        salto_valido = 1'b0; stall = 1'b0; ack_espurio = 1'b0;

        // Reset mid-request drops im_req at once
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; ack_delay = 5;
        @(negedge clk);
        @(negedge clk);
        check_b("mid_req_up", im_req, 1'b1);
        check_w("mid_req_dir", im_dir, PC_A);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_b("async_drop_req", im_req, 1'b0);
        check_b("async_error_clr", error_alineacion, 1'b0);
        check_w("async_dir", im_dir, PC_A);
        @(negedge clk);
        reset = 1'b0;

        // Randomized run
        dato_aleatorio = 1'b1; ack_aleatorio = 1'b1; ack_espurio = 1'b1;
        ack_delay = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (reset)                                    reset = 1'b0;
            else if (m_err && $urandom_range(0, 3) == 0)  reset = 1'b1;
            else if ($urandom_range(0, 499) == 0)         reset = 1'b1;
            stall = ($urandom_range(0, 2) == 0);
            salto_valido = !reset && (m_boot >= 2) && ($urandom_range(0, 5) == 0);
            result_suma = {$urandom, $urandom};
            result_suma[1:0] = ($urandom_range(0, 79) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
